// File: rtl/spi_ram_wrapper.sv
// SPI loopback: master -> slave -> dual-port RAM on one clock, 16-bit {addr,data} frames.
// Define SPI_RAM_BITS_SENT_EN to keep the last-frame capture on spi_bits_sent (tied to 0 otherwise).

module spi_ram_dp #(
    parameter int DEPTH = 256,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         we_a_i,
    input  logic [W-1:0] addr_a_i,
    input  logic [W-1:0] wdata_a_i,
    input  logic [W-1:0] addr_b_i,
    output logic [W-1:0] rdata_b_o
);
    logic [W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we_a_i) mem[addr_a_i] <= wdata_a_i;
    end

    assign rdata_b_o = mem[addr_b_i];
endmodule

module spi_ram_wrapper #(
    parameter int N         = 2,
    parameter bit cpol      = 1'b0,
    parameter bit cpha      = 1'b0,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   ram_rst_n_a,
    input  logic                   ram_rst_n_b,
    input  logic                   startTx,
    input  logic                   startRx,
    input  logic                   which_slave_enabled,
    input  logic [2*ADDR_SIZE-1:0] spi_din,
    output logic                   spi_mosi,
    output logic                   spi_miso,
    output logic [2*ADDR_SIZE-1:0] spi_bits_sent,
    output logic [N-1:0]           spi_cs
);
    localparam int AS   = ADDR_SIZE;
    localparam int FW   = 2 * ADDR_SIZE;
    localparam int CNTW = $clog2(2 * FW);
    localparam int CW   = $clog2(FW) + 1;
    localparam int IW   = $clog2(AS);
    localparam logic [CNTW-1:0] LAST = CNTW'(2 * FW - 1);

    typedef enum logic [1:0] {M_IDLE, M_ASSERT, M_SHIFT, M_DONE} mst_t;
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} slv_t;

    mst_t            mst_q;
    logic [CNTW-1:0] cnt_q;
    logic [FW-1:0]   tx_sr_q;
    logic            rd_q;
    logic [N-1:0]    cs_q;
    logic [N-1:0]    cs_sel_d;
    logic            mosi_q;
    logic            sclk_q;
    logic            sclk_d;
    logic            sclk_edge, lead_ev, trail_ev, smp_ev, shf_ev;

    slv_t            slv_q;
    logic [CW-1:0]   scnt_q;
    logic [AS-2:0]   sr_q;
    logic [AS-1:0]   addr_q;
    logic            miso_q;
    logic            sel;
    logic [IW-1:0]   bit_idx;
    logic            we_a;
    logic [AS-1:0]   wdata_a;
    logic [AS-1:0]   rdata_b;

    always_comb begin
        cs_sel_d = '1;
        for (int j = 0; j < N; j++) begin
            if (int'(which_slave_enabled) == j) cs_sel_d[j] = 1'b0;
        end
    end

    // SCLK toggles every clk in SHIFT and is back at idle level when DONE starts.
    assign sclk_d    = (mst_q == M_SHIFT) ? ((cnt_q == LAST) ? cpol : ~sclk_q) : cpol;
    assign sclk_edge = (sclk_d != sclk_q);
    assign lead_ev   = sclk_edge && (sclk_d != cpol);
    assign trail_ev  = sclk_edge && (sclk_d == cpol);
    assign smp_ev    = cpha ? trail_ev : lead_ev;
    assign shf_ev    = cpha ? lead_ev : trail_ev;

    always_ff @(posedge clk) begin
        if (ram_rst_n_a) begin
            mst_q   <= M_IDLE;
            cnt_q   <= '0;
            tx_sr_q <= '0;
            rd_q    <= 1'b0;
            cs_q    <= '1;
            mosi_q  <= 1'b0;
            sclk_q  <= cpol;
        end else begin
            sclk_q <= sclk_d;
            case (mst_q)
                M_IDLE: begin
                    cs_q   <= '1;
                    mosi_q <= 1'b0;
                    if (startTx || startRx) begin
                        tx_sr_q <= spi_din;
                        rd_q    <= !startTx;
                        cs_q    <= cs_sel_d;
                        mst_q   <= M_ASSERT;
                    end
                end
                M_ASSERT: begin
                    cnt_q <= '0;
                    mst_q <= M_SHIFT;
                    if (!cpha) begin
                        mosi_q  <= tx_sr_q[FW-1];
                        tx_sr_q <= {tx_sr_q[FW-2:0], 1'b0};
                    end
                end
                M_SHIFT: begin
                    cnt_q <= cnt_q + CNTW'(1);
                    if (shf_ev) begin
                        mosi_q  <= tx_sr_q[FW-1];
                        tx_sr_q <= {tx_sr_q[FW-2:0], 1'b0};
                    end
                    if (cnt_q == LAST) begin
                        mosi_q <= 1'b0;
                        mst_q  <= M_DONE;
                    end
                end
                M_DONE: begin
                    cs_q   <= '1;
                    mosi_q <= 1'b0;
                    mst_q  <= M_IDLE;
                end
                default: mst_q <= M_IDLE;
            endcase
        end
    end

`ifdef SPI_RAM_BITS_SENT_EN
    logic [FW-1:0] din_q;
    logic [AS-1:0] rx_q;
    logic [AS-1:0] rx_d;
    logic [FW-1:0] bits_q;

    assign rx_d = smp_ev ? {rx_q[AS-2:0], miso_q} : rx_q;

    always_ff @(posedge clk) begin
        if (ram_rst_n_a) begin
            din_q  <= '0;
            rx_q   <= '0;
            bits_q <= '0;
        end else begin
            if (mst_q == M_IDLE && (startTx || startRx)) din_q <= spi_din;
            rx_q <= rx_d;
            if (mst_q == M_SHIFT && cnt_q == LAST)
                bits_q <= rd_q ? {din_q[FW-1:AS], rx_d} : din_q;
        end
    end

    assign spi_bits_sent = bits_q;
`else
    assign spi_bits_sent = '0;
`endif

    assign sel     = ~&cs_q;
    assign bit_idx = IW'(CW'(FW - 1) - scnt_q);
    assign wdata_a = {sr_q, mosi_q};
    // The final data bit is taken straight off MOSI so the write lands on the 16th sample.
    assign we_a    = (slv_q == S_DATA) && sel && smp_ev && (scnt_q == CW'(FW - 1)) &&
                     !rd_q && !ram_rst_n_a && !ram_rst_n_b;

    always_ff @(posedge clk) begin
        if (ram_rst_n_b) begin
            slv_q  <= S_IDLE;
            scnt_q <= '0;
            sr_q   <= '0;
            addr_q <= '0;
            miso_q <= 1'b0;
        end else if (!sel) begin
            slv_q  <= S_IDLE;
            scnt_q <= '0;
            miso_q <= 1'b0;
        end else begin
            case (slv_q)
                S_IDLE: slv_q <= S_ADDR;
                S_ADDR: begin
                    if (smp_ev) begin
                        sr_q   <= {sr_q[AS-3:0], mosi_q};
                        scnt_q <= scnt_q + CW'(1);
                        if (scnt_q == CW'(AS - 1)) begin
                            addr_q <= {sr_q, mosi_q};
                            slv_q  <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (smp_ev) begin
                        sr_q   <= {sr_q[AS-3:0], mosi_q};
                        scnt_q <= scnt_q + CW'(1);
                    end
                    if (shf_ev)
                        miso_q <= (rd_q && scnt_q < CW'(FW)) ? rdata_b[bit_idx] : 1'b0;
                end
                default: slv_q <= S_IDLE;
            endcase
        end
    end

    spi_ram_dp #(
        .DEPTH (MEM_DEPTH),
        .W     (AS)
    ) ram_inst (
        .clk       (clk),
        .we_a_i    (we_a),
        .addr_a_i  (addr_q),
        .wdata_a_i (wdata_a),
        .addr_b_i  (addr_q),
        .rdata_b_o (rdata_b)
    );

    assign spi_cs   = cs_q;
    assign spi_mosi = mosi_q;
    assign spi_miso = miso_q;
endmodule

// File: tb/tb_spi_ram_wrapper.sv
// Bench for spi_ram_wrapper: per-cycle frame-timeline model plus directed literal checks.
module tb_spi_ram_wrapper;
    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, startTx, startRx, ws;
    logic [15:0] din;
    logic        spi_mosi, spi_miso;
    logic [15:0] spi_bits_sent;
    logic [1:0]  spi_cs;

    always #5 clk = ~clk;

    spi_ram_wrapper dut (
        .clk                 (clk),
        .ram_rst_n_a         (rst_a),
        .ram_rst_n_b         (rst_b),
        .startTx             (startTx),
        .startRx             (startRx),
        .which_slave_enabled (ws),
        .spi_din             (din),
        .spi_mosi            (spi_mosi),
        .spi_miso            (spi_miso),
        .spi_bits_sent       (spi_bits_sent),
        .spi_cs              (spi_cs)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bits_exp(input logic [15:0] v);
`ifdef SPI_RAM_BITS_SENT_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    // Timeline model: a frame launched at an edge owns cycles 1..34 after it.
    logic [7:0]  mmem [0:255];
    bit          m_busy = 0;
    int          m_r = 0;
    bit          m_tx;
    logic        m_ws;
    logic [15:0] m_din;
    logic [7:0]  m_rdata;
    logic [15:0] m_bits = 16'h0;
    bit          chk_en = 0;

    function automatic bit m_sel();
        return int'(m_ws) < N;
    endfunction

    always @(posedge clk) begin
        if (rst_a || rst_b) begin
            m_busy = 0;
            m_r    = 0;
            m_bits = 16'h0;
        end else if (!m_busy) begin
            if (startTx || startRx) begin
                m_busy  = 1;
                m_r     = 1;
                m_tx    = startTx;
                m_ws    = ws;
                m_din   = din;
                m_rdata = mmem[din[15:8]];
            end
        end else begin
            m_r++;
            if (m_r == 34) begin
                if (m_tx) begin
                    m_bits = m_din;
                    if (m_sel()) mmem[m_din[15:8]] = m_din[7:0];
                end else begin
                    m_bits = {m_din[15:8], m_sel() ? m_rdata : 8'h00};
                end
            end
            if (m_r == 35) m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0] e_cs;
            logic       e_mosi, e_miso;
            int         bi;
            e_cs   = 2'b11;
            e_mosi = 1'b0;
            e_miso = 1'b0;
            bi     = (m_r - 2) / 2;
            if (m_busy && m_sel()) e_cs[m_ws] = 1'b0;
            if (m_busy && m_r >= 2 && m_r <= 33) e_mosi = m_din[15 - bi];
            if (m_busy && !m_tx && m_sel() && m_r >= 18 && m_r <= 33) e_miso = m_rdata[15 - bi];
            chk("cyc_cs", 32'(spi_cs), 32'(e_cs));
            chk("cyc_mosi", 32'(spi_mosi), 32'(e_mosi));
            chk("cyc_miso", 32'(spi_miso), 32'(e_miso));
            chk("cyc_bits", 32'(spi_bits_sent), 32'(bits_exp(m_bits)));
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] v);
        dut.ram_inst.mem[a] = v;
        mmem[a] = v;
    endtask

    task automatic run_frame(input bit tx, input bit rx, input logic w, input logic [15:0] d,
                             output int cs_low, output logic [1:0] cs_seen,
                             output logic [15:0] mo, output logic [15:0] mi);
        @(posedge clk); #1;
        startTx = tx; startRx = rx; ws = w; din = d;
        @(posedge clk); #1;
        startTx = 0; startRx = 0; ws = ~w; din = 16'hFFFF;
        cs_low = 0; cs_seen = 2'b11; mo = 16'h0; mi = 16'h0;
        for (int j = 1; j <= 38; j++) begin
            @(negedge clk);
            if (spi_cs != 2'b11) begin
                cs_low++;
                cs_seen = spi_cs;
            end
            if (j >= 2 && j <= 33 && (j % 2) == 0) begin
                mo = {mo[14:0], spi_mosi};
                mi = {mi[14:0], spi_miso};
            end
        end
    endtask

    int          cs_low;
    logic [1:0]  cs_seen;
    logic [15:0] mo, mi;

    initial begin
        rst_a = 1; rst_b = 1; startTx = 0; startRx = 0; ws = 0; din = 16'h0;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_cs", 32'(spi_cs), 32'h3);
        chk("rst_mosi", 32'(spi_mosi), 32'h0);
        chk("rst_miso", 32'(spi_miso), 32'h0);
        chk("rst_bits", 32'(spi_bits_sent), 32'h0);
        @(posedge clk); #1;
        rst_a = 0; rst_b = 0;

        run_frame(1, 0, 1'b0, 16'hABCD, cs_low, cs_seen, mo, mi);
        chk("wr_cs_len", 32'(cs_low), 32'd34);
        chk("wr_cs_val", 32'(cs_seen), 32'h2);
        chk("wr_mosi", 32'(mo), 32'hABCD);
        chk("wr_miso", 32'(mi), 32'h0);
        chk("wr_mem", 32'(dut.ram_inst.mem[8'hAB]), 32'hCD);
        chk("wr_bits", 32'(spi_bits_sent), 32'(bits_exp(16'hABCD)));

        run_frame(0, 1, 1'b0, 16'hABBB, cs_low, cs_seen, mo, mi);
        chk("rd_mosi", 32'(mo), 32'hABBB);
        chk("rd_miso", 32'(mi), 32'h00CD);
        chk("rd_bits", 32'(spi_bits_sent), 32'(bits_exp(16'hABCD)));
        chk("rd_mem", 32'(dut.ram_inst.mem[8'hAB]), 32'hCD);

        run_frame(1, 0, 1'b1, 16'h1234, cs_low, cs_seen, mo, mi);
        chk("s1_wr_cs", 32'(cs_seen), 32'h1);
        chk("s1_wr_mem", 32'(dut.ram_inst.mem[8'h12]), 32'h34);

        run_frame(0, 1, 1'b1, 16'h12AB, cs_low, cs_seen, mo, mi);
        chk("s1_rd_cs", 32'(cs_seen), 32'h1);
        chk("s1_rd_miso", 32'(mi), 32'h0034);
        chk("s1_rd_bits", 32'(spi_bits_sent), 32'(bits_exp(16'h1234)));

        run_frame(1, 1, 1'b0, 16'h5A77, cs_low, cs_seen, mo, mi);
        chk("prio_mem", 32'(dut.ram_inst.mem[8'h5A]), 32'h77);
        chk("prio_miso", 32'(mi), 32'h0);
        chk("prio_bits", 32'(spi_bits_sent), 32'(bits_exp(16'h5A77)));

        preload(8'h55, 8'h11);
        @(posedge clk); #1;
        startTx = 1; ws = 0; din = 16'h5566;
        @(posedge clk); #1;
        startTx = 0;
        repeat (11) @(posedge clk);
        #1;
        rst_a = 1; rst_b = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_cs", 32'(spi_cs), 32'h3);
        chk("abort_mosi", 32'(spi_mosi), 32'h0);
        chk("abort_bits", 32'(spi_bits_sent), 32'h0);
        @(posedge clk); #1;
        rst_a = 0; rst_b = 0;
        repeat (40) @(posedge clk);
        chk("abort_mem", 32'(dut.ram_inst.mem[8'h55]), 32'h11);

        #1;
        preload(8'h00, 8'hFF);
        run_frame(0, 1, 1'b0, 16'h0000, cs_low, cs_seen, mo, mi);
        chk("pre_miso", 32'(mi), 32'h00FF);
        chk("pre_bits", 32'(spi_bits_sent), 32'(bits_exp(16'h00FF)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
